// File: rtl/cmsdk_fpga_mem_loader_if.sv
// Byte-stream and memory-port bundle for the FPGA memory loader.
// The master side is the loader itself; the slave side is the byte source plus the RAM.
interface cmsdk_fpga_mem_loader_if #(
  parameter int AW = 16
);
  logic          BYTE_VALID;
  logic [7:0]    BYTE_DATA;
  logic          BYTE_READY;
  logic [AW-3:0] ADDR;
  logic [31:0]   WDATA;
  logic [3:0]    WREN;
  logic          CS;
  logic [31:0]   RDATA;

  modport master (
    input  BYTE_VALID, BYTE_DATA, RDATA,
    output BYTE_READY, ADDR, WDATA, WREN, CS
  );

  modport slave (
    output BYTE_VALID, BYTE_DATA, RDATA,
    input  BYTE_READY, ADDR, WDATA, WREN, CS
  );
endinterface

// File: rtl/cmsdk_fpga_mem_loader.sv
// Streams little-endian bytes into a word RAM as single-lane writes, sums the loaded
// words, and optionally reads everything back to confirm the RAM holds the same sum.

module cmsdk_fpga_mem_loader_lane #(
  parameter int VEC_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             ld,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] q
);
  always_ff @(posedge CLK) begin
    if (RESET || clr) q <= '0;
    else if (ld)      q <= din;
  end
endmodule

module cmsdk_fpga_mem_loader #(
  parameter int AW        = 16,
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic [AW-3:0]          LEN_WORDS,
  cmsdk_fpga_mem_loader_if.master bus,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERROR,
  output logic [31:0]            CHECKSUM
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int WW        = AW - 2;
  localparam int STAGES    = 1;

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DRAIN, FINISH} state_t;

  state_t                              state;
  logic [WW-1:0]                       len, widx, ridx;
  logic [1:0]                          bidx;
  logic [31:0]                         load_sum, rb_sum;
  logic [STAGES:0]                     vld_pipe;
  logic [NUM_LANES-2:0][VEC_W-1:0]     lane_q;
  logic [NUM_LANES-1:0]                lane_sel;
  logic                                accept, start_ok, last_byte, rd_issue;
  logic [31:0]                         word, load_sum_nxt, rb_sum_nxt;

  assign accept    = bus.BYTE_VALID && bus.BYTE_READY;
  assign start_ok  = START && (state == IDLE || state == FINISH);
  assign last_byte = accept && (bidx == 2'd3) && (widx == len - WW'(1));
  assign rd_issue  = (state == VERIFY) && (ridx != len);
  assign lane_sel  = NUM_LANES'(1) << bidx;

  // Lanes 0..2 are held; the top lane comes straight from the stream so the
  // completed word can be summed on the same edge that accepts its last byte.
  for (genvar g = 0; g < NUM_LANES - 1; g++) begin : g_lane
    cmsdk_fpga_mem_loader_lane #(.VEC_W(VEC_W)) u_lane (
      .CLK  (CLK),
      .RESET(RESET),
      .clr  (start_ok),
      .ld   (accept && lane_sel[g]),
      .din  (bus.BYTE_DATA),
      .q    (lane_q[g])
    );
    assign word[g*VEC_W +: VEC_W] = lane_q[g];
  end
  assign word[(NUM_LANES-1)*VEC_W +: VEC_W] = bus.BYTE_DATA;

  assign load_sum_nxt = load_sum + word;
  assign rb_sum_nxt   = rb_sum + (vld_pipe[STAGES] ? bus.RDATA : 32'd0);

  assign BUSY = (state == LOAD) || (state == VERIFY) || (state == DRAIN);
  assign DONE = (state == FINISH);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= IDLE;
      len            <= '0;
      widx           <= '0;
      ridx           <= '0;
      bidx           <= '0;
      load_sum       <= '0;
      rb_sum         <= '0;
      vld_pipe       <= '0;
      bus.BYTE_READY <= 1'b0;
      bus.CS         <= 1'b0;
      bus.WREN       <= '0;
      bus.ADDR       <= '0;
      bus.WDATA      <= '0;
      ERROR          <= 1'b0;
      CHECKSUM       <= '0;
    end else begin
      bus.CS   <= 1'b0;
      bus.WREN <= '0;
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_issue};
      rb_sum   <= rb_sum_nxt;
      if (start_ok) begin
        len            <= LEN_WORDS;
        widx           <= '0;
        ridx           <= '0;
        bidx           <= '0;
        load_sum       <= '0;
        rb_sum         <= '0;
        ERROR          <= 1'b0;
        CHECKSUM       <= '0;
        // A zero-length load passes through LOAD for one cycle with the stream closed.
        bus.BYTE_READY <= (LEN_WORDS != '0);
        state          <= LOAD;
      end else begin
        case (state)
          LOAD: begin
            if (len == '0) state <= FINISH;
            if (accept) begin
              bus.CS    <= 1'b1;
              bus.WREN  <= lane_sel;
              bus.WDATA <= {NUM_LANES{bus.BYTE_DATA}};
              bus.ADDR  <= widx;
              bidx      <= bidx + 2'd1;
              if (bidx == 2'd3) begin
                widx     <= widx + WW'(1);
                load_sum <= load_sum_nxt;
              end
              if (last_byte) begin
                bus.BYTE_READY <= 1'b0;
                if (VERIFY_EN) begin
                  state <= VERIFY;
                end else begin
                  state    <= FINISH;
                  CHECKSUM <= load_sum_nxt;
                end
              end
            end
          end
          // First VERIFY cycle carries the final write, so reads start one cycle later.
          VERIFY: begin
            if (rd_issue) begin
              bus.CS   <= 1'b1;
              bus.ADDR <= ridx;
              ridx     <= ridx + WW'(1);
            end else begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            state    <= FINISH;
            ERROR    <= (rb_sum_nxt != load_sum);
            CHECKSUM <= load_sum;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmsdk_fpga_mem_loader.sv
// Bench for the memory loader: two instances (verify on/off) share one byte stream,
// each with its own 1-cycle RAM; results are checked against a word-level model.
module tb_cmsdk_fpga_mem_loader;
  localparam int AW    = 10;
  localparam int WW    = AW - 2;
  localparam int DEPTH = 1 << WW;

  typedef logic [WW+36-1:0] wr_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic [WW-1:0] LEN = '0;
  logic          valid = 1'b0;
  logic [7:0]    data = '0;
  logic          busy0, done0, err0, busy1, done1, err1;
  logic [31:0]   sum0, sum1;
  logic          stuck0 = 1'b0;

  logic [31:0] ram0 [DEPTH];
  logic [31:0] ram1 [DEPTH];
  logic [31:0] words [$];
  wr_t         wq0 [$];
  wr_t         wq1 [$];
  int          rq0 [$];
  int          rq1 [$];
  int          cyc = 0;
  int          lastw0 = -1, lastw1 = -1, firstr0 = -1, donec1 = -1;
  int          errors = 0, checks = 0;

  always #5 CLK = ~CLK;

  cmsdk_fpga_mem_loader_if #(.AW(AW)) bus0 ();
  cmsdk_fpga_mem_loader_if #(.AW(AW)) bus1 ();

  assign bus0.BYTE_VALID = valid;
  assign bus0.BYTE_DATA  = data;
  assign bus1.BYTE_VALID = valid;
  assign bus1.BYTE_DATA  = data;

  cmsdk_fpga_mem_loader #(.AW(AW), .VERIFY_EN(1'b1)) dut0 (
    .CLK(CLK), .RESET(RESET), .START(START), .LEN_WORDS(LEN), .bus(bus0),
    .BUSY(busy0), .DONE(done0), .ERROR(err0), .CHECKSUM(sum0));

  cmsdk_fpga_mem_loader #(.AW(AW), .VERIFY_EN(1'b0)) dut1 (
    .CLK(CLK), .RESET(RESET), .START(START), .LEN_WORDS(LEN), .bus(bus1),
    .BUSY(busy1), .DONE(done1), .ERROR(err1), .CHECKSUM(sum1));

  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{we[k]}};
    return m;
  endfunction

  // RAM 0 can model a stuck-at-0 data bit 0
  always @(posedge CLK) begin
    if (bus0.CS) begin
      if (bus0.WREN != 4'd0)
        ram0[bus0.ADDR] <= (ram0[bus0.ADDR] & ~lane_mask(bus0.WREN)) |
                           (bus0.WDATA & lane_mask(bus0.WREN) & (stuck0 ? 32'hFFFF_FFFE : 32'hFFFF_FFFF));
      else
        bus0.RDATA <= ram0[bus0.ADDR];
    end
    if (bus1.CS) begin
      if (bus1.WREN != 4'd0)
        ram1[bus1.ADDR] <= (ram1[bus1.ADDR] & ~lane_mask(bus1.WREN)) | (bus1.WDATA & lane_mask(bus1.WREN));
      else
        bus1.RDATA <= ram1[bus1.ADDR];
    end
  end

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (bus0.CS) begin
      if (bus0.WREN != 4'd0) begin
        wq0.push_back({bus0.ADDR, bus0.WREN, bus0.WDATA});
        lastw0 = cyc;
      end else begin
        if (rq0.size() == 0) firstr0 = cyc;
        rq0.push_back(int'(bus0.ADDR));
      end
    end
    if (bus1.CS) begin
      if (bus1.WREN != 4'd0) begin
        wq1.push_back({bus1.ADDR, bus1.WREN, bus1.WDATA});
        lastw1 = cyc;
      end else begin
        rq1.push_back(int'(bus1.ADDR));
      end
    end
    if (done1 && donec1 < 0) donec1 = cyc;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " rst0"}, 96'({bus0.BYTE_READY, bus0.CS, bus0.WREN, bus0.ADDR, bus0.WDATA,
                             busy0, done0, err0, sum0}), 96'd0);
    chk({tag, " rst1"}, 96'({bus1.BYTE_READY, bus1.CS, bus1.WREN, bus1.ADDR, bus1.WDATA,
                             busy1, done1, err1, sum1}), 96'd0);
  endtask

  task automatic clear_mon();
    wq0.delete(); wq1.delete(); rq0.delete(); rq1.delete();
    lastw0 = -1; lastw1 = -1; firstr0 = -1; donec1 = -1;
  endtask

  task automatic pulse_start(input int n);
    @(posedge CLK); #1;
    START = 1'b1; LEN = WW'(n);
    @(posedge CLK); #1;
    START = 1'b0;
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit st);
    bit ok;
    ok = 1'b0;
    valid = 1'b1; data = b; START = st;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge CLK); ok = bus0.BYTE_READY;
      @(posedge CLK); #1; START = 1'b0;
    end
    if (!ok) begin
      checks++; errors++;
      $error("FAIL byte_accept: got no handshake, expected one within 50 cycles");
    end
    valid = 1'b0;
  endtask

  // Load words[0..n-1]; optional random gaps and a START pulse riding on byte start_at.
  task automatic run(input int n, input bit gaps, input int start_at, input string tag);
    logic [31:0] s, rs, rw;
    wr_t         ew;
    int          idx;
    pulse_start(n);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        if (gaps) repeat ($urandom_range(0, 3)) begin
          valid = 1'b0; data = 8'($urandom);
          @(posedge CLK); #1;
        end
        send_byte(words[i][8*k +: 8], (4*i + k) == start_at);
      end
    @(negedge CLK);
    chk({tag, " ready_drop0"}, 96'(bus0.BYTE_READY), 96'd0);
    chk({tag, " ready_drop1"}, 96'(bus1.BYTE_READY), 96'd0);
    for (int t = 0; t < 100 && !(done0 && done1); t++) @(negedge CLK);
    @(posedge CLK); #1;
    chk({tag, " done0"}, 96'(done0), 96'd1);
    chk({tag, " done1"}, 96'(done1), 96'd1);
    s = 32'd0; rs = 32'd0;
    for (int i = 0; i < n; i++) begin
      s  += words[i];
      rs += stuck0 ? (words[i] & 32'hFFFF_FFFE) : words[i];
    end
    chk({tag, " sum0"}, 96'(sum0), 96'(s));
    chk({tag, " sum1"}, 96'(sum1), 96'(s));
    chk({tag, " err0"}, 96'(err0), 96'(rs != s));
    chk({tag, " err1"}, 96'(err1), 96'd0);
    chk({tag, " nwr0"}, 96'(wq0.size()), 96'(4*n));
    chk({tag, " nwr1"}, 96'(wq1.size()), 96'(4*n));
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        idx = 4*i + k;
        ew  = {WW'(i), 4'(1 << k), {4{words[i][8*k +: 8]}}};
        if (idx < wq0.size()) chk($sformatf("%s wr0[%0d]", tag, idx), 96'(wq0[idx]), 96'(ew));
        if (idx < wq1.size()) chk($sformatf("%s wr1[%0d]", tag, idx), 96'(wq1[idx]), 96'(ew));
      end
    chk({tag, " nrd0"}, 96'(rq0.size()), 96'(n));
    chk({tag, " nrd1"}, 96'(rq1.size()), 96'd0);
    for (int j = 0; j < rq0.size(); j++) chk($sformatf("%s rdaddr[%0d]", tag, j), 96'(rq0[j]), 96'(j));
    chk({tag, " wr_before_rd"}, 96'(firstr0 > lastw0), 96'd1);
    chk({tag, " done_after_wr1"}, 96'(donec1 >= lastw1), 96'd1);
    for (int i = 0; i < n; i++) begin
      rw = stuck0 ? (words[i] & 32'hFFFF_FFFE) : words[i];
      chk($sformatf("%s ram0[%0d]", tag, i), 96'(ram0[i]), 96'(rw));
      chk($sformatf("%s ram1[%0d]", tag, i), 96'(ram1[i]), 96'(words[i]));
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_rst("reset");
    RESET = 1'b0;

    words = {32'h4433_2211, 32'h8877_6655};
    run(2, 1'b0, -1, "load2");
    chk("load2 sum_const", 96'(sum0), 96'h0000_0000_0000_0000_CCAA_8866);

    // Zero length, restarted from FINISH: DONE drops, then returns on the second edge.
    pulse_start(0);
    @(negedge CLK);
    chk("zero done_drop", 96'(done0), 96'd0);
    @(negedge CLK);
    chk("zero done0", 96'(done0), 96'd1);
    chk("zero done1", 96'(done1), 96'd1);
    repeat (3) @(negedge CLK);
    chk("zero sum0", 96'(sum0), 96'd0);
    chk("zero err0", 96'(err0), 96'd0);
    chk("zero no_cs", 96'(wq0.size() + rq0.size() + wq1.size() + rq1.size()), 96'd0);

    stuck0 = 1'b1;
    words  = {32'h0000_0001};
    run(1, 1'b0, -1, "stuck");
    chk("stuck err_const", 96'(err0), 96'd1);
    chk("stuck sum_const", 96'(sum0), 96'd1);
    stuck0 = 1'b0;

    words = {32'hFFFF_FFFF, 32'h0000_0002};
    run(2, 1'b0, -1, "wrap");
    run(2, 1'b1, -1, "wrapgap");
    chk("wrapgap sum_const", 96'(sum0), 96'd1);

    words = {32'($urandom), 32'($urandom), 32'($urandom)};
    run(3, 1'b1, 5, "startbusy");

    // Reset after three bytes of a two-word load.
    words = {32'($urandom), 32'($urandom)};
    pulse_start(2);
    for (int k = 0; k < 3; k++) send_byte(words[0][8*k +: 8], 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk_rst("midreset");
    @(posedge CLK); #1;
    RESET = 1'b0;
    run(2, 1'b0, -1, "afterreset");

    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, 10));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(32'($urandom));
      run(n, 1'($urandom), -1, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmsdk_fpga_mem_loader.md
CMSDK_FPGA_MEM_LOADER -- requirements
Module: cmsdk_fpga_mem_loader

Interface
REQ-001 Parameter AW, default 16: byte-address width of the target memory; the word address is AW-2 bits.
REQ-002 Parameter VERIFY_EN, default 1: 1 = readback verify pass after load; 0 = skip verify.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 START  in  1  one-cycle request to begin a load; ignored unless the FSM is in IDLE or FINISH.
REQ-006 LEN_WORDS  in  AW-2  number of 32-bit words to load, sampled on accepted START.
REQ-007 BYTE_VALID  in  1  byte stream valid.
REQ-008 BYTE_DATA  in  8  byte stream data; little-endian, word i byte k = memory byte 4i+k.
REQ-009 BYTE_READY  out  1  byte stream ready; a transfer occurs when BYTE_VALID and BYTE_READY are both 1.
REQ-010 ADDR  out  AW-2  word address to memory (bits AW-1:2).
REQ-011 WDATA  out  32  write data to memory.
REQ-012 WREN  out  4  per-byte-lane write enables.
REQ-013 CS  out  1  memory select; read data returns on RDATA one cycle after CS=1 with WREN=0.
REQ-014 RDATA  in  32  read data from memory.
REQ-015 BUSY  out  1  high in LOAD, VERIFY, DRAIN.
REQ-016 DONE  out  1  high in FINISH (sticky until START or RESET).
REQ-017 ERROR  out  1  verify mismatch flag; meaningful when DONE=1.
REQ-018 CHECKSUM  out  32  modulo-2^32 sum of loaded words.

Function
REQ-019 FSM states IDLE, LOAD, VERIFY, DRAIN, FINISH; reset state IDLE.
REQ-020 IDLE/FINISH + START: latch LEN_WORDS, clear the word index, byte index, sums and ERROR; go to LOAD, or to FINISH next cycle if LEN_WORDS=0.
REQ-021 With LEN_WORDS=0: CHECKSUM=0, ERROR=0, and no CS is issued.
REQ-022 BYTE_READY=1 only in LOAD.
REQ-023 Each accepted byte produces, in the following cycle, exactly one write: CS=1, WREN=4'b0001<<k, WDATA={4{byte}}, ADDR=word index.
REQ-024 In all cycles with no write pending, CS=0 and WREN=0.
REQ-025 The byte index k wraps 3->0; at that wrap the word index increments and the assembled word is added to the load sum.
REQ-026 BYTE_VALID gaps stall the transfer without any effect on result.
REQ-027 After the last byte of word LEN_WORDS-1 is accepted, BYTE_READY drops in the next cycle.
REQ-028 After that last byte, the FSM goes to VERIFY if VERIFY_EN=1, otherwise to FINISH.
REQ-029 The final write completes before the first verify read.
REQ-030 VERIFY issues reads on consecutive cycles: CS=1, WREN=0, ADDR=0..LEN_WORDS-1.
REQ-031 RDATA is sampled one cycle after each read and summed into the readback sum.
REQ-032 After the last read, the FSM enters DRAIN for one cycle to capture the final RDATA.
REQ-033 From DRAIN the FSM enters FINISH, with ERROR=1 iff the readback sum differs from the load sum.
REQ-034 CHECKSUM shows the load sum; it is held from entry to FINISH until the next accepted START.
REQ-035 Sums wrap modulo 2^32 with no overflow flag.
REQ-036 The word index never exceeds 2^(AW-2)-1 because LEN_WORDS is AW-2 bits; no address wrap occurs.
REQ-037 START during BUSY is ignored, with no state change.
REQ-038 START in FINISH restarts the load; DONE drops in the next cycle.

Reset
REQ-039 RESET=1 at any clock edge, including mid-LOAD or mid-VERIFY, forces IDLE.
REQ-040 After reset: BYTE_READY=0, CS=0, WREN=0, ADDR=0, WDATA=0, BUSY=0, DONE=0, ERROR=0, CHECKSUM=0, and all counters 0.
REQ-041 A pending write is discarded when RESET is asserted.

Verification
REQ-042 Load test: LEN_WORDS=2, bytes 11 22 33 44 55 66 77 88, with a 1-cycle-latency RAM model -> eight single-lane writes (addr 0 lanes 0..3, addr 1 lanes 0..3); RAM words 0x44332211 and 0x88776655; CHECKSUM=0xCCAA8866; DONE=1; ERROR=0.
REQ-043 Zero length: LEN_WORDS=0 with START -> DONE=1 on the second edge after START, CS never asserted, CHECKSUM=0.
REQ-044 Verify failure: RAM model with data bit 0 stuck at 0, load word 0x00000001 -> CHECKSUM=0x00000001, ERROR=1.
REQ-045 Wrap and stall: words 0xFFFFFFFF and 0x00000002 with random BYTE_VALID gaps -> CHECKSUM=0x00000001, ERROR=0, write sequence identical to the gap-free run.
REQ-046 Reset mid-load: RESET pulsed after 3 bytes -> all outputs at REQ-040 values next cycle; a subsequent START and full load completes normally.
REQ-047 START during BUSY: START pulsed mid-LOAD -> no effect on state, counters or result.
REQ-048 VERIFY_EN=0: no read cycles occur, and DONE follows the last write.
